decode_writeback: RTL and testbench
===================================

// Module: decode_writeback
// PURPOSE
//  Y86-64 SEQ decode + write-back stage; sits directly upstream of execute.
//  Derives srcA/srcB/dstE/dstM from icode/rA/rB/cnd and reads valA/valB combinationally.
//  Owns the 15-entry x 64-bit architectural register file.
//  Commits valE/valM from execute/memory on the rising clock edge.
// PARAMETERS
//  STACK_INIT  64'd0  reset value of %rsp (reg 4); all other regs reset to 0
// PORTS
//  clk     in   1   single clock; all writes on rising edge
//  rst_n   in   1   asynchronous, active-low reset
//  icode   in   4   instruction code of the current instruction
//  rA      in   4   register specifier A (4'hF = none)
//  rB      in   4   register specifier B (4'hF = none)
//  cnd     in   1   condition from execute; gates the cmovXX dstE
//  valE    in   64  ALU result to write to dstE
//  valM    in   64  memory read data to write to dstM
//  wb_en   in   1   commit enable; 0 = stall/halt, no register write
//  srcA    out  4   decoded read register A
//  srcB    out  4   decoded read register B
//  dstE    out  4   decoded E write register
//  dstM    out  4   decoded M write register
//  valA    out  64  R[srcA]; 0 when srcA == 4'hF
//  valB    out  64  R[srcB]; 0 when srcB == 4'hF
// BEHAVIOUR
//  - srcA: rA for icode 2,4,6,A; 4 (%rsp) for icode 9,B; else F.
//  - srcB: rB for icode 4,5,6; 4 for icode 8,9,A,B; else F.
//  - dstE: icode 2 -> (cnd ? rB : F); rB for icode 3,6; 4 for icode 8,9,A,B; else F.
//  - dstM: rA for icode 5,B; else F.
//  - Undefined icode: all four IDs = F, so no reads and no writes.
//  - Reads are combinational, zero latency. A write becomes visible on reads the cycle after the edge.
//  - Write at posedge clk when wb_en=1: R[dstE]<=valE if dstE!=F; R[dstM]<=valM if dstM!=F.
//  - dstE == dstM (popq %rsp): valM wins; exactly one write occurs.
//  - Reg F is never stored; a write to F is dropped.
//  - Full 64-bit values; no truncation or sign handling.
//  - rst_n=0 (async, mid-cycle allowed): regs 0-3 and 5-14 <= 0, reg 4 <= STACK_INIT.
//    During and after reset, valA/valB reflect these values.
//  - Reset asserted on the same edge as a write: reset wins.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - If srcX matches a live (wb_en=1) dstM or dstE, valX returns the in-flight write data that cycle.
//    - Priority: valM, then valE, then stored value.
//  Undefined: valA/valB always return stored contents (plain SEQ timing).
// STRUCTURE
//  - Shared package y86_pkg holds:
//    - icode localparams: IHALT..IPOPQ = 0..B.
//    - Register IDs: RRSP=4'h4, RNONE=4'hF.
//    - typedef reg_id_t [3:0] and word_t [63:0].
//  - Sub-module regfile: 2 async read ports, 2 write ports with M-over-E priority, async reset.
//  - Decode logic stays in decode_writeback.
// TESTING
//  1. Reset with STACK_INIT=64'h100 -> icode=A, rA=3: valA=0, valB=64'h100.
//  2. icode=3, rB=2, valE=42, wb_en=1, one edge; then icode=6, rA=2, rB=2.
//     -> valA=valB=42, dstE=2.
//  3. icode=2, rA=1, rB=5, cnd=0, valE=7, edge -> dstE=F, R5 unchanged.
//     Same with cnd=1 -> R5=7.
//  4. icode=B, rA=4, valE=8, valM=99, edge -> R4=99 (valM priority).
//  5. wb_en=0, icode=3, rB=6, valE=5, edge -> R6 unchanged (0).
//     Assert rst_n=0 mid-cycle -> all regs cleared immediately, without a clock edge.
//  6. With REGFILE_BYPASS_EN: icode=3, rB=7, valE=11, wb_en=1 -> srcB=F, valB=0.
//     Then icode=6, rA=7, dstE=7 live -> valA=in-flight valE before the edge.
//     Without the macro: valA=old R7 until the edge.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs, word types.
// No logic, only types and constants.
// Imported by the decode/write-back interface, regfile and top.
package y86_pkg;

  typedef logic [3:0]  reg_id_t;
  typedef logic [63:0] word_t;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam reg_id_t RRSP  = 4'h4;
  localparam reg_id_t RNONE = 4'hF;

  localparam int NUM_REGS = 15;

endpackage

// File: rtl/decode_writeback_if.sv
// Bundle of decode inputs, commit data and decoded IDs/operands.
// Purely combinational signal grouping, no latency.
// No backpressure; wb_en is the only commit qualifier.
interface decode_writeback_if;
  import y86_pkg::*;

  logic [3:0] icode;
  reg_id_t    rA;
  reg_id_t    rB;
  logic       cnd;
  word_t      valE;
  word_t      valM;
  logic       wb_en;

  reg_id_t    srcA;
  reg_id_t    srcB;
  reg_id_t    dstE;
  reg_id_t    dstM;
  word_t      valA;
  word_t      valB;

  // Upstream/driver side: supplies instruction fields and commit data.
  modport master (
    output icode, rA, rB, cnd, valE, valM, wb_en,
    input  srcA, srcB, dstE, dstM, valA, valB
  );

  // Decode/write-back stage side.
  modport slave (
    input  icode, rA, rB, cnd, valE, valM, wb_en,
    output srcA, srcB, dstE, dstM, valA, valB
  );

endinterface

// File: rtl/decode_writeback_regfile.sv
// 15x64 register file, 2 async read ports, 2 write ports (M beats E). Optional REGFILE_BYPASS_EN.
// Reads zero latency; writes visible the cycle after the edge (same cycle with bypass).
// No backpressure; i_wb_en=0 suppresses both writes.
module regfile
  import y86_pkg::*;
#(
  parameter word_t STACK_INIT = 64'd0
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_wb_en,
  input  reg_id_t i_srcA,
  input  reg_id_t i_srcB,
  input  reg_id_t i_dstE,
  input  reg_id_t i_dstM,
  input  word_t   i_valE,
  input  word_t   i_valM,
  output word_t   o_valA,
  output word_t   o_valB
);

  word_t r_regs [NUM_REGS];
  word_t w_stored_a;
  word_t w_stored_b;

  // Register 15 does not exist; a write to it is simply dropped.
  // The M write is issued last so it overrides E when both target one register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= (i == int'(RRSP)) ? STACK_INIT : '0;
      end
    end else if (i_wb_en) begin
      if (i_dstE != RNONE) r_regs[i_dstE] <= i_valE;
      if (i_dstM != RNONE) r_regs[i_dstM] <= i_valM;
    end
  end

  // Stored contents, with the "none" ID reading as zero.
  always_comb begin
    w_stored_a = '0;
    w_stored_b = '0;
    if (i_srcA != RNONE) w_stored_a = r_regs[i_srcA];
    if (i_srcB != RNONE) w_stored_b = r_regs[i_srcB];
  end

`ifdef REGFILE_BYPASS_EN
  // Forward the in-flight commit data: valM first, then valE, then storage.
  always_comb begin
    o_valA = w_stored_a;
    o_valB = w_stored_b;
    if (i_wb_en && i_srcA != RNONE) begin
      if (i_srcA == i_dstM)      o_valA = i_valM;
      else if (i_srcA == i_dstE) o_valA = i_valE;
    end
    if (i_wb_en && i_srcB != RNONE) begin
      if (i_srcB == i_dstM)      o_valB = i_valM;
      else if (i_srcB == i_dstE) o_valB = i_valE;
    end
  end
`else
  // Plain SEQ timing: reads only ever see committed state.
  always_comb begin
    o_valA = w_stored_a;
    o_valB = w_stored_b;
  end
`endif

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode + write-back: derives src/dst IDs, reads operands, commits valE/valM (REGFILE_BYPASS_EN optional).
// Decode and reads are zero latency; commit on rising clk when wb_en=1.
// No backpressure; wb_en=0 stalls the commit only.
module decode_writeback
  import y86_pkg::*;
#(
  parameter word_t STACK_INIT = 64'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  decode_writeback_if.slave  dw
);

  reg_id_t w_srcA;
  reg_id_t w_srcB;
  reg_id_t w_dstE;
  reg_id_t w_dstM;
  word_t   w_valA;
  word_t   w_valB;

  // Register ID decode; unknown icodes leave every ID at "none".
  always_comb begin
    w_srcA = RNONE;
    w_srcB = RNONE;
    w_dstE = RNONE;
    w_dstM = RNONE;
    case (dw.icode)
      IRRMOVQ: begin
        w_srcA = dw.rA;
        w_dstE = dw.cnd ? dw.rB : RNONE;
      end
      IIRMOVQ: begin
        w_dstE = dw.rB;
      end
      IRMMOVQ: begin
        w_srcA = dw.rA;
        w_srcB = dw.rB;
      end
      IMRMOVQ: begin
        w_srcB = dw.rB;
        w_dstM = dw.rA;
      end
      IOPQ: begin
        w_srcA = dw.rA;
        w_srcB = dw.rB;
        w_dstE = dw.rB;
      end
      ICALL: begin
        w_srcB = RRSP;
        w_dstE = RRSP;
      end
      IRET: begin
        w_srcA = RRSP;
        w_srcB = RRSP;
        w_dstE = RRSP;
      end
      IPUSHQ: begin
        w_srcA = dw.rA;
        w_srcB = RRSP;
        w_dstE = RRSP;
      end
      IPOPQ: begin
        w_srcA = RRSP;
        w_srcB = RRSP;
        w_dstE = RRSP;
        w_dstM = dw.rA;
      end
      default: begin
        w_srcA = RNONE;
      end
    endcase
  end

  regfile #(
    .STACK_INIT (STACK_INIT)
  ) u_regfile (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_wb_en (dw.wb_en),
    .i_srcA  (w_srcA),
    .i_srcB  (w_srcB),
    .i_dstE  (w_dstE),
    .i_dstM  (w_dstM),
    .i_valE  (dw.valE),
    .i_valM  (dw.valM),
    .o_valA  (w_valA),
    .o_valB  (w_valB)
  );

  assign dw.srcA = w_srcA;
  assign dw.srcB = w_srcB;
  assign dw.dstE = w_dstE;
  assign dw.dstM = w_dstM;
  assign dw.valA = w_valA;
  assign dw.valB = w_valB;

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback with STACK_INIT = 64'h100.
// Stimulus pushes expected fields; a negedge monitor pops and compares.
// Builds with or without REGFILE_BYPASS_EN.
module tb_decode_writeback;
  import y86_pkg::*;

  localparam word_t SI = 64'h100;
  localparam int F_SRCA = 0, F_SRCB = 1, F_DSTE = 2, F_DSTM = 3, F_VALA = 4, F_VALB = 5;

  logic clk;
  logic rst_n;

  decode_writeback_if dw_if_i ();

  decode_writeback #(.STACK_INIT(SI)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dw    (dw_if_i)
  );

  typedef struct {
    string       name;
    int          fld;
    logic [63:0] val;
  } chk_t;

  chk_t sb_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic exp_chk(input string name, input int fld, input logic [63:0] val);
    chk_t c;
    c.name = name;
    c.fld  = fld;
    c.val  = val;
    sb_q.push_back(c);
  endtask

  task automatic exp_ids(input string name, input reg_id_t sa, input reg_id_t sb,
                         input reg_id_t de, input reg_id_t dm);
    exp_chk({name, ".srcA"}, F_SRCA, {60'd0, sa});
    exp_chk({name, ".srcB"}, F_SRCB, {60'd0, sb});
    exp_chk({name, ".dstE"}, F_DSTE, {60'd0, de});
    exp_chk({name, ".dstM"}, F_DSTM, {60'd0, dm});
  endtask

  task automatic set_in(input logic [3:0] ic, input reg_id_t a, input reg_id_t b,
                        input logic c, input word_t e, input word_t m, input logic we);
    dw_if_i.icode = ic;
    dw_if_i.rA    = a;
    dw_if_i.rB    = b;
    dw_if_i.cnd   = c;
    dw_if_i.valE  = e;
    dw_if_i.valM  = m;
    dw_if_i.wb_en = we;
  endtask

  // Apply the next instruction just after a rising edge.
  task automatic drive(input logic [3:0] ic, input reg_id_t a, input reg_id_t b,
                       input logic c, input word_t e, input word_t m, input logic we);
    @(posedge clk);
    #1;
    set_in(ic, a, b, c, e, m, we);
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  initial begin : monitor
    chk_t        c;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        c = sb_q.pop_front();
        case (c.fld)
          F_SRCA:  act = {60'd0, dw_if_i.srcA};
          F_SRCB:  act = {60'd0, dw_if_i.srcB};
          F_DSTE:  act = {60'd0, dw_if_i.dstE};
          F_DSTM:  act = {60'd0, dw_if_i.dstM};
          F_VALA:  act = dw_if_i.valA;
          default: act = dw_if_i.valB;
        endcase
        n_tests++;
        if (act !== c.val) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h", c.name, act, c.val);
        end
      end
    end
  end

  initial begin : stim
    // Reset state, observed while reset is held.
    rst_n = 1'b0;
    set_in(IPUSHQ, 4'h3, RNONE, 1'b0, '0, '0, 1'b0);
    exp_ids("rst_push", 4'h3, RRSP, RRSP, RNONE);
    exp_chk("rst_push.valA", F_VALA, 64'd0);
    exp_chk("rst_push.valB", F_VALB, SI);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // irmovq 42 -> R2
    drive(IIRMOVQ, RNONE, 4'h2, 1'b0, 64'd42, '0, 1'b1);
    exp_ids("irmov", RNONE, RNONE, 4'h2, RNONE);
    exp_chk("irmov.valB", F_VALB, 64'd0);

    // opq R2,R2 reads the committed value
    drive(IOPQ, 4'h2, 4'h2, 1'b0, '0, '0, 1'b0);
    exp_ids("opq_r2", 4'h2, 4'h2, 4'h2, RNONE);
    exp_chk("opq_r2.valA", F_VALA, 64'd42);
    exp_chk("opq_r2.valB", F_VALB, 64'd42);

    // cmov not taken: no write to R5
    drive(IRRMOVQ, 4'h1, 4'h5, 1'b0, 64'd7, '0, 1'b1);
    exp_ids("cmov_nt", 4'h1, RNONE, RNONE, RNONE);
    exp_chk("cmov_nt.valA", F_VALA, 64'd0);
    drive(IOPQ, 4'h5, 4'h1, 1'b0, '0, '0, 1'b0);
    exp_chk("r5_unchanged", F_VALA, 64'd0);

    // cmov taken: R5 <= 7
    drive(IRRMOVQ, 4'h1, 4'h5, 1'b1, 64'd7, '0, 1'b1);
    exp_chk("cmov_t.dstE", F_DSTE, 64'd5);
    drive(IOPQ, 4'h5, 4'h1, 1'b0, '0, '0, 1'b0);
    exp_chk("r5_written", F_VALA, 64'd7);

    // popq %rsp: valM wins over valE
    drive(IPOPQ, 4'h4, RNONE, 1'b0, 64'd8, 64'd99, 1'b1);
    exp_ids("popq_rsp", RRSP, RRSP, RRSP, RRSP);
`ifdef REGFILE_BYPASS_EN
    exp_chk("popq_rsp.valA", F_VALA, 64'd99);
`else
    exp_chk("popq_rsp.valA", F_VALA, SI);
`endif
    drive(IOPQ, 4'h4, 4'h4, 1'b0, '0, '0, 1'b0);
    exp_chk("rsp_after_pop", F_VALA, 64'd99);

    // wb_en=0: irmovq to R6 does not commit
    drive(IIRMOVQ, RNONE, 4'h6, 1'b0, 64'd5, '0, 1'b0);
    exp_chk("stall.dstE", F_DSTE, 64'd6);
    drive(IOPQ, 4'h6, 4'h2, 1'b0, '0, '0, 1'b0);
    exp_chk("r6_stalled", F_VALA, 64'd0);
    exp_chk("r2_kept", F_VALB, 64'd42);

    // R7 <= 11, then opq R7,R7 with valE=33 in flight
    drive(IIRMOVQ, RNONE, 4'h7, 1'b0, 64'd11, '0, 1'b1);
    exp_chk("irmov7.srcB", F_SRCB, {60'd0, RNONE});
    exp_chk("irmov7.valB", F_VALB, 64'd0);
    drive(IOPQ, 4'h7, 4'h7, 1'b0, 64'd33, '0, 1'b1);
`ifdef REGFILE_BYPASS_EN
    exp_chk("fwd7.valA", F_VALA, 64'd33);
    exp_chk("fwd7.valB", F_VALB, 64'd33);
`else
    exp_chk("fwd7.valA", F_VALA, 64'd11);
    exp_chk("fwd7.valB", F_VALB, 64'd11);
`endif
    drive(IOPQ, 4'h7, 4'h7, 1'b0, '0, '0, 1'b0);
    exp_chk("r7_after", F_VALA, 64'd33);

    // Mid-cycle async reset clears registers without an edge
    drive(IOPQ, 4'h2, 4'h5, 1'b0, '0, '0, 1'b0);
    #1 rst_n = 1'b0;
    exp_chk("arst.r2", F_VALA, 64'd0);
    exp_chk("arst.r5", F_VALB, 64'd0);

    // A write attempted while reset is held is lost
    drive(IIRMOVQ, RNONE, 4'h2, 1'b0, 64'd55, '0, 1'b1);
    exp_chk("rst_wr.dstE", F_DSTE, 64'd2);
    drive(IPUSHQ, 4'h2, RNONE, 1'b0, '0, '0, 1'b0);
    exp_chk("rst_wins.r2", F_VALA, 64'd0);
    exp_chk("rst_wins.rsp", F_VALB, SI);
    #1 rst_n = 1'b1;

    // mrmovq: full 64-bit valM into R3
    drive(IMRMOVQ, 4'h3, 4'h4, 1'b0, 64'd1, 64'h1234_5678_9ABC_DEF0, 1'b1);
    exp_ids("mrmov", RNONE, RRSP, RNONE, 4'h3);
    exp_chk("mrmov.valB", F_VALB, SI);
    drive(IOPQ, 4'h3, 4'h3, 1'b0, '0, '0, 1'b0);
    exp_chk("r3_full.valA", F_VALA, 64'h1234_5678_9ABC_DEF0);
    exp_chk("r3_full.valB", F_VALB, 64'h1234_5678_9ABC_DEF0);

    // Undefined icode: no reads, no writes
    drive(4'hC, 4'h1, 4'h2, 1'b1, 64'd77, 64'd88, 1'b1);
    exp_ids("undef", RNONE, RNONE, RNONE, RNONE);
    exp_chk("undef.valA", F_VALA, 64'd0);
    exp_chk("undef.valB", F_VALB, 64'd0);
    drive(IOPQ, 4'h1, 4'h2, 1'b0, '0, '0, 1'b0);
    exp_chk("undef_nowr.r1", F_VALA, 64'd0);
    exp_chk("undef_nowr.r2", F_VALB, 64'd0);

    // call: %rsp as source and destination
    drive(ICALL, 4'h1, 4'h2, 1'b0, '0, '0, 1'b0);
    exp_ids("call", RNONE, RRSP, RRSP, RNONE);
    exp_chk("call.valB", F_VALB, SI);

    // Let the monitor drain, then confirm nothing was left unchecked.
    @(negedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
